// File: rtl/lives_manager.sv
// Player life bookkeeping: death freeze, post-respawn immunity with frog blink, game over.
// Optional feature: define EXTRA_LIFE_EN to award a life on level_up (capped at MAX_LIVES).
module lives_manager #(
    parameter int MAX_LIVES     = 3,
    parameter int HIT_FRAMES    = 60,
    parameter int INVULN_FRAMES = 90,
    parameter int BLINK_SHIFT   = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       collision,
    input  logic       start,
    input  logic       level_up,
    output logic [1:0] lives,
    output logic       game_over,
    output logic       respawn,
    output logic       freeze,
    output logic       frog_visible
);

    localparam int FMAX = (HIT_FRAMES > INVULN_FRAMES) ? HIT_FRAMES : INVULN_FRAMES;
    localparam int FW   = $clog2(FMAX + 1);
    localparam logic [1:0]    MAX_L       = 2'(MAX_LIVES);
    localparam logic [FW-1:0] HIT_LAST    = FW'(HIT_FRAMES - 1);
    localparam logic [FW-1:0] INVULN_LAST = FW'(INVULN_FRAMES - 1);

    typedef enum logic [2:0] {
        ST_READY  = 3'd0,
        ST_PLAY   = 3'd1,
        ST_DYING  = 3'd2,
        ST_INVULN = 3'd3,
        ST_OVER   = 3'd4
    } state_t;

    state_t        state_r, state_s;
    logic [FW-1:0] fcnt_r, fcnt_s;
    logic [1:0]    lives_s;
    logic          respawn_s, freeze_s, game_over_s, frog_visible_s;

`ifndef EXTRA_LIFE_EN
    logic unused_level_up_s;
    assign unused_level_up_s = level_up;
`endif

    // Next-state, next-lives and next-output computation
    always_comb begin
        state_s   = state_r;
        fcnt_s    = fcnt_r;
        lives_s   = lives;
        respawn_s = 1'b0;
        case (state_r)
            ST_READY: begin
                if (start) begin
                    state_s   = ST_PLAY;
                    respawn_s = 1'b1;
                end else begin
                    state_s = ST_READY;
                end
            end
            ST_PLAY: begin
                // Collision leaves PLAY, so a held collision costs only one life
                if (collision) begin
                    if (lives > 2'd1) begin
                        state_s = ST_DYING;
                        lives_s = lives - 2'd1;
                    end else begin
                        state_s = ST_OVER;
                        lives_s = 2'd0;
                    end
`ifdef EXTRA_LIFE_EN
                end else if (level_up && (lives < MAX_L)) begin
                    lives_s = lives + 2'd1;
`endif
                end else begin
                    state_s = ST_PLAY;
                end
            end
            ST_DYING: begin
                if (frame_tick) begin
                    if (fcnt_r == HIT_LAST) begin
                        state_s   = ST_INVULN;
                        respawn_s = 1'b1;
                    end else begin
                        fcnt_s = fcnt_r + FW'(1);
                    end
                end else begin
                    fcnt_s = fcnt_r;
                end
            end
            ST_INVULN: begin
                if (frame_tick) begin
                    if (fcnt_r == INVULN_LAST) begin
                        state_s = ST_PLAY;
                    end else begin
                        fcnt_s = fcnt_r + FW'(1);
                    end
                end else begin
                    fcnt_s = fcnt_r;
                end
`ifdef EXTRA_LIFE_EN
                if (level_up && (lives < MAX_L)) begin
                    lives_s = lives + 2'd1;
                end else begin
                    lives_s = lives;
                end
`endif
            end
            ST_OVER: begin
                if (start) begin
                    state_s = ST_READY;
                    lives_s = MAX_L;
                end else begin
                    lives_s = 2'd0;
                end
            end
            default: begin
                state_s = ST_READY;
                lives_s = MAX_L;
            end
        endcase

        if (state_s != state_r) begin
            fcnt_s = {FW{1'b0}};
        end else begin
            fcnt_s = fcnt_s;
        end

        freeze_s       = (state_s == ST_READY) || (state_s == ST_DYING) || (state_s == ST_OVER);
        game_over_s    = (state_s == ST_OVER);
        frog_visible_s = (state_s == ST_INVULN) ? ~fcnt_s[BLINK_SHIFT] : 1'b1;
    end

    // State, frame counter and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_READY;
            fcnt_r       <= {FW{1'b0}};
            lives        <= MAX_L;
            game_over    <= 1'b0;
            respawn      <= 1'b0;
            freeze       <= 1'b1;
            frog_visible <= 1'b1;
        end else begin
            state_r      <= state_s;
            fcnt_r       <= fcnt_s;
            lives        <= lives_s;
            game_over    <= game_over_s;
            respawn      <= respawn_s;
            freeze       <= freeze_s;
            frog_visible <= frog_visible_s;
        end
    end

endmodule

// File: tb/tb_lives_manager.sv
// Self-checking bench for lives_manager: vector table plus hand-written multi-cycle sequences,
// expected outputs queued when stimulus is driven and compared after the clock edge.
module tb_lives_manager;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_tick = 1'b0;
    logic       collision = 1'b0;
    logic       start = 1'b0;
    logic       level_up = 1'b0;
    logic [1:0] lives;
    logic       game_over, respawn, freeze, frog_visible;

    int compared = 0;
    int mismatched = 0;

    typedef struct {
        logic       st, co, ft, lu;
        logic [1:0] lv;
        logic       go, rs, fz, fv;
        string      nm;
    } vec_t;

    vec_t sb_q[$];
    vec_t tbl[8];

    lives_manager dut (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .collision(collision),
        .start(start), .level_up(level_up), .lives(lives), .game_over(game_over),
        .respawn(respawn), .freeze(freeze), .frog_visible(frog_visible)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic st, input logic co, input logic ft, input logic lu,
                                input logic [1:0] lv, input logic go, input logic rs,
                                input logic fz, input logic fv, input string nm);
        vec_t v;
        v.st = st; v.co = co; v.ft = ft; v.lu = lu;
        v.lv = lv; v.go = go; v.rs = rs; v.fz = fz; v.fv = fv; v.nm = nm;
        return v;
    endfunction

    task automatic chk(input string nm, input string what, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s.%s: got %0d expected %0d", nm, what, act, exp);
        end
    endtask

    task automatic compare_outputs(input vec_t e);
        chk(e.nm, "lives", int'(lives), int'(e.lv));
        chk(e.nm, "game_over", int'(game_over), int'(e.go));
        chk(e.nm, "respawn", int'(respawn), int'(e.rs));
        chk(e.nm, "freeze", int'(freeze), int'(e.fz));
        chk(e.nm, "frog_visible", int'(frog_visible), int'(e.fv));
    endtask

    // Drive one cycle of inputs, queue the expectation, compare after the edge
    task automatic apply(input vec_t v);
        vec_t e;
        start = v.st; collision = v.co; frame_tick = v.ft; level_up = v.lu;
        sb_q.push_back(v);
        @(posedge clk);
        #1;
        start = 1'b0; collision = 1'b0; frame_tick = 1'b0; level_up = 1'b0;
        if (sb_q.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL scoreboard: got empty queue expected one entry");
        end else begin
            e = sb_q.pop_front();
            compare_outputs(e);
        end
    endtask

    task automatic dying_loop(input logic [1:0] l);
        for (int i = 1; i <= 60; i++) begin
            if (i == 60) begin
                apply(mk(1'b0, 1'b0, 1'b1, 1'b0, l, 1'b0, 1'b1, 1'b0, 1'b1, "dying_last_tick"));
                apply(mk(1'b0, 1'b0, 1'b0, 1'b0, l, 1'b0, 1'b0, 1'b0, 1'b1, "respawn_once"));
            end else begin
                apply(mk(1'b0, (i == 5), 1'b1, 1'b0, l, 1'b0, 1'b0, 1'b1, 1'b1, "dying_tick"));
                apply(mk(1'b0, 1'b0, 1'b0, 1'b0, l, 1'b0, 1'b0, 1'b1, 1'b1, "dying_idle"));
            end
        end
    endtask

    task automatic invuln_loop(input logic [1:0] l);
        logic fv;
        for (int i = 1; i <= 90; i++) begin
            fv = (i == 90) ? 1'b1 : (((i / 8) % 2) == 0);
            apply(mk(1'b0, (i == 10), 1'b1, 1'b0, l, 1'b0, 1'b0, 1'b0, fv, "invuln_tick"));
            apply(mk(1'b0, 1'b0, 1'b0, 1'b0, l, 1'b0, 1'b0, 1'b0, fv, "invuln_idle"));
        end
    endtask

    initial begin
        tbl[0] = mk(1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 1'b0, 1'b1, 1'b0, 1'b1, "start_play");
        tbl[1] = mk(1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1, "play_idle");
        tbl[2] = mk(1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1, "level_up_at_max");
        tbl[3] = mk(1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1, "tick_in_play");
        tbl[4] = mk(1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1, "start_in_play");
        tbl[5] = mk(1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 1'b1, 1'b1, "hit_to_dying");
        tbl[6] = mk(1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 1'b1, 1'b1, "held_collision");
        tbl[7] = mk(1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b1, 1'b1, "level_up_dying");

        // Reset values
        #12;
        compare_outputs(mk(1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 1'b0, 1'b0, 1'b1, 1'b1, "reset"));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        apply(mk(1'b0, 1'b1, 1'b1, 1'b1, 2'd3, 1'b0, 1'b0, 1'b1, 1'b1, "ready_ignores"));

        for (int i = 0; i < 8; i++) begin
            apply(tbl[i]);
        end

        dying_loop(2'd2);
        invuln_loop(2'd2);

`ifdef EXTRA_LIFE_EN
        apply(mk(1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1, "extra_life"));
        apply(mk(1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1, "extra_life_sat"));
        apply(mk(1'b0, 1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b1, 1'b1, "collision_beats_lvl"));
        dying_loop(2'd2);
        invuln_loop(2'd2);
`else
        apply(mk(1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b1, "level_up_unused"));
`endif

        // Collision and frame tick together: one decrement
        apply(mk(1'b0, 1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 1'b1, 1'b1, "hit_with_tick"));
        dying_loop(2'd1);
        invuln_loop(2'd1);

        apply(mk(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b1, "last_hit_over"));
        apply(mk(1'b0, 1'b1, 1'b1, 1'b1, 2'd0, 1'b1, 1'b0, 1'b1, 1'b1, "over_ignores"));
        apply(mk(1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 1'b0, 1'b0, 1'b1, 1'b1, "restart_ready"));
        apply(mk(1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 1'b0, 1'b1, 1'b0, 1'b1, "second_start"));
        apply(mk(1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1, "respawn_single"));

        // Reset in the middle of DYING
        apply(mk(1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 1'b1, 1'b1, "hit_before_reset"));
        for (int i = 0; i < 5; i++) begin
            apply(mk(1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 1'b1, 1'b1, "dying_pre_reset"));
        end
        #2;
        rst_n = 1'b0;
        #1;
        compare_outputs(mk(1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 1'b0, 1'b0, 1'b1, 1'b1, "async_reset"));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            apply(mk(1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 1'b0, 1'b0, 1'b1, 1'b1, "post_reset_ready"));
        end
        apply(mk(1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 1'b0, 1'b1, 1'b0, 1'b1, "start_after_reset"));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
